// File: rtl/logicnet_input_quantizer.sv
// Quantizes a serial stream of signed feature words against per-feature thresholds and
// assembles a double-buffered vector for layer-0. Optional framing check: LOGICNET_FRAME_CHECK_EN.
module logicnet_input_quantizer #(
  parameter int NUM_FEATURES = 16,
  parameter int FEAT_W       = 16,
  parameter int Q_W          = 2,
  parameter int CNT_W        = $clog2(NUM_FEATURES)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        cfg_we,
  input  logic [CNT_W+1:0]            cfg_addr,
  input  logic [FEAT_W-1:0]           cfg_data,
  input  logic                        s_valid,
  output logic                        s_ready,
  input  logic [FEAT_W-1:0]           s_data,
  input  logic                        s_last,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic [NUM_FEATURES*Q_W-1:0] m_data,
  output logic                        err_frame
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_FEATURES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FULL  = 2'd1,
    STALL = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [NUM_FEATURES-1:0][2:0][FEAT_W-1:0] thr_q, thr_d;
  logic [NUM_FEATURES-1:0][Q_W-1:0]         asm_q, asm_d, asm_full;
  logic [NUM_FEATURES-1:0][Q_W-1:0]         m_data_q, m_data_d;
  logic [CNT_W-1:0]                         cnt_q, cnt_d;

  logic [CNT_W-1:0] cfg_idx;
  logic [1:0]       cfg_sel;
  logic [2:0]       gt;
  logic [Q_W-1:0]   code;
  logic             hs, last_slot, frame_err, frame_done;

  assign cfg_idx = cfg_addr[CNT_W+1:2];
  assign cfg_sel = cfg_addr[1:0];

  always_comb begin
    thr_d = thr_q;
    if (cfg_we && (cfg_sel != 2'd3) && (int'(cfg_idx) < NUM_FEATURES))
      thr_d[cfg_idx][cfg_sel] = cfg_data;
  end

  // Code is the count of thresholds strictly exceeded, so unordered thresholds still work.
  always_comb begin
    for (int k = 0; k < 3; k++)
      gt[k] = $signed(s_data) > $signed(thr_q[cnt_q][k]);
    code = Q_W'(gt[0]) + Q_W'(gt[1]) + Q_W'(gt[2]);
  end

  assign s_ready   = (state_q != STALL);
  assign m_valid   = (state_q != IDLE);
  assign m_data    = m_data_q;
  assign hs        = s_valid & s_ready;
  assign last_slot = (cnt_q == LAST_IDX);

`ifdef LOGICNET_FRAME_CHECK_EN
  logic err_q, err_d;

  // s_last must coincide exactly with the final slot; either mismatch drops the frame.
  assign frame_err = hs & (s_last ^ last_slot);
  assign err_d     = err_q | frame_err;
  assign err_frame = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end
`else
  logic unused_s_last;

  assign unused_s_last = s_last;
  assign frame_err     = 1'b0;
  assign err_frame     = 1'b0;
`endif

  assign frame_done = hs & last_slot & ~frame_err;

  // The final slot bypasses the assembly register so the vector lands one cycle after the last word.
  always_comb begin
    asm_full        = asm_q;
    asm_full[cnt_q] = code;
    asm_d           = hs ? asm_full : asm_q;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (hs) cnt_d = (last_slot || frame_err) ? '0 : cnt_q + 1'b1;
  end

  always_comb begin
    state_d  = state_q;
    m_data_d = m_data_q;
    case (state_q)
      IDLE: begin
        if (frame_done) begin
          state_d  = FULL;
          m_data_d = asm_full;
        end
      end
      FULL: begin
        if (frame_done) begin
          if (m_ready) m_data_d = asm_full;
          else         state_d  = STALL;
        end else if (m_ready) begin
          state_d = IDLE;
        end
      end
      STALL: begin
        if (m_ready) begin
          state_d  = FULL;
          m_data_d = asm_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      thr_q    <= '0;
      asm_q    <= '0;
      m_data_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      thr_q    <= thr_d;
      asm_q    <= asm_d;
      m_data_q <= m_data_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_logicnet_input_quantizer.sv
// Directed bench for logicnet_input_quantizer: thresholds, boundaries, stall, streaming,
// mid-frame reset and (when LOGICNET_FRAME_CHECK_EN is defined) frame errors.
module tb_logicnet_input_quantizer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_we = 1'b0;
  logic [5:0]  cfg_addr = '0;
  logic [15:0] cfg_data = '0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [15:0] s_data = '0;
  logic        s_last = 1'b0;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [31:0] m_data;
  logic        err_frame;

  int total = 0;
  int bad   = 0;

  logic        mon_en = 1'b0;
  int          mon_cyc = 0, pulses = 0, drops = 0, gap_bad = 0, last_pulse = 0;

  logic [15:0] pat_a [4];
  logic [15:0] pat_b [4];

  logicnet_input_quantizer dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .err_frame(err_frame)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mon_en) begin
      mon_cyc <= mon_cyc + 1;
      if (!s_ready) drops <= drops + 1;
      if (m_valid) begin
        if (pulses > 0 && (mon_cyc + 1 - last_pulse) != 16) gap_bad <= gap_bad + 1;
        last_pulse <= mon_cyc + 1;
        pulses     <= pulses + 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cfg_write(input int idx, input int sel, input logic [15:0] val);
    cfg_we   = 1'b1;
    cfg_addr = {idx[3:0], sel[1:0]};
    cfg_data = val;
    @(negedge clk);
    cfg_we   = 1'b0;
  endtask

  task automatic send_word(input logic [15:0] d, input logic last);
    int n;
    n       = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    while (!s_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!s_ready) begin
      total++;
      bad++;
      $error("FAIL send_timeout: observed s_ready=0 expected 1");
    end
    @(negedge clk);
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  // Words lo..hi-1 of a 16-word frame; s_last marks word 15.
  task automatic send_range(input int sel, input int lo, input int hi);
    for (int i = lo; i < hi; i++)
      send_word(sel == 0 ? pat_a[i % 4] : pat_b[i % 4], i == 15);
  endtask

  initial begin
    pat_a[0] = 16'd200;  pat_a[1] = 16'd50; pat_a[2] = -16'sd50;  pat_a[3] = -16'sd200;
    pat_b[0] = 16'd100;  pat_b[1] = 16'd0;  pat_b[2] = -16'sd100; pat_b[3] = 16'd101;

    #12;
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_s_ready", s_ready, 1);
    chk("rst_err", err_frame, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int f = 0; f < 16; f++) begin
      cfg_write(f, 0, -16'sd100);
      cfg_write(f, 1, 16'd0);
      cfg_write(f, 2, 16'd100);
    end
    cfg_write(1, 3, 16'h8000);

    // Frame A, held with m_ready low: codes 3,2,1,0 per group of four.
    send_range(0, 0, 15);
    chk("a_pre_last_valid", m_valid, 0);
    send_range(0, 15, 16);
    chk("a_valid", m_valid, 1);
    chk("a_data", m_data, 32'h1B1B1B1B);

    // Frame B exercises the strict boundaries: 100->2, 0->1, -100->0, 101->3.
    send_range(1, 0, 16);
    chk("stall_s_ready", s_ready, 0);
    chk("stall_m_valid", m_valid, 1);
    chk("stall_hold_a", m_data, 32'h1B1B1B1B);
    @(negedge clk);
    chk("stall_s_ready_2", s_ready, 0);
    chk("stall_hold_a_2", m_data, 32'h1B1B1B1B);
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
    chk("b_valid", m_valid, 1);
    chk("b_data", m_data, 32'hC6C6C6C6);
    @(negedge clk);
    chk("b_s_ready", s_ready, 1);
    chk("b_data_stable", m_data, 32'hC6C6C6C6);
    m_ready = 1'b1;
    @(negedge clk);
    chk("b_drained", m_valid, 0);

    // Four frames streamed with no gaps and m_ready held high.
    mon_en = 1'b1;
    for (int fr = 0; fr < 4; fr++) send_range(0, 0, 16);
    repeat (2) @(negedge clk);
    mon_en = 1'b0;
    chk("stream_pulses", pulses, 4);
    chk("stream_drops", drops, 0);
    chk("stream_gaps", gap_bad, 0);
    chk("stream_data", m_data, 32'h1B1B1B1B);

    // Partial frame then reset; thresholds fall back to 0, so codes are 3,3,0,0.
    send_range(0, 0, 7);
    rst_n = 1'b0;
    #1;
    chk("mrst_m_valid", m_valid, 0);
    chk("mrst_m_data", m_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send_range(0, 0, 9);
    chk("mrst_no_early_frame", m_valid, 0);
    send_range(0, 9, 16);
    chk("mrst_valid", m_valid, 1);
    chk("mrst_data", m_data, 32'h0F0F0F0F);
    @(negedge clk);

`ifdef LOGICNET_FRAME_CHECK_EN
    for (int i = 0; i < 10; i++) send_word(pat_a[i % 4], i == 9);
    @(negedge clk);
    chk("short_no_valid", m_valid, 0);
    chk("short_err", err_frame, 1);
    send_range(0, 0, 16);
    chk("after_err_valid", m_valid, 1);
    chk("after_err_data", m_data, 32'h0F0F0F0F);
    chk("after_err_sticky", err_frame, 1);
`else
    for (int i = 0; i < 10; i++) send_word(pat_a[i % 4], i == 9);
    chk("nochk_no_valid", m_valid, 0);
    send_range(0, 10, 16);
    chk("nochk_valid", m_valid, 1);
    chk("nochk_data", m_data, 32'h0F0F0F0F);
    chk("nochk_err", err_frame, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
